// File: rtl/ctrl_seq.sv
// ctrl_seq -- microcode control sequencer for the 8-bit datapath.
//
// Holds a T-state step counter and a halt latch, and decodes
// {opcode, step, flags} into a 16-bit active-high control word that gates
// every register load, bus drive and counter enable of the datapath.
//
// Ports:
//   clk        system clock, all state changes on posedge
//   reset      synchronous, active-high; step<=0, halted<=0
//   step_en    1 = advance this cycle, 0 = freeze step and suppress control
//   opcode     current instruction opcode (IR upper nibble)
//   flag_c     registered carry flag (used by JC at T2 only)
//   flag_z     registered zero flag  (used by JZ at T2 only)
//   ctrl       control word: 15 HLT, 14 MI, 13 RI, 12 RO, 11 IO, 10 II,
//              9 AI, 8 AO, 7 EO, 6 SU, 5 BI, 4 OI, 3 CE, 2 CO, 1 J, 0 FI
//   step       current T-state (0..4)
//   halted     halt latched; cleared only by reset
//   instr_done high in the final step of an instruction when step_en=1
//
// ctrl is combinational from the registered step/halted and the current
// inputs, so the datapath loads on the same posedge that advances step.
module ctrl_seq #(
  parameter int OP_W   = 4,
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_en,
  input  logic [OP_W-1:0]   opcode,
  input  logic              flag_c,
  input  logic              flag_z,
  output logic [15:0]       ctrl,
  output logic [STEP_W-1:0] step,
  output logic              halted,
  output logic              instr_done
);

  // Control word bits.
  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  // Opcodes. 9..13 are undefined and fall into the decode defaults (NOP).
  localparam logic [OP_W-1:0] OP_LDA = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(3);
  localparam logic [OP_W-1:0] OP_STA = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LDI = OP_W'(5);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(6);
  localparam logic [OP_W-1:0] OP_JC  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_JZ  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_OUT = OP_W'(14);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(15);

  localparam logic [STEP_W-1:0] STEP_T0  = STEP_W'(0);
  localparam logic [STEP_W-1:0] STEP_T1  = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_T2  = STEP_W'(2);
  localparam logic [STEP_W-1:0] STEP_T3  = STEP_W'(3);
  localparam logic [STEP_W-1:0] STEP_T4  = STEP_W'(4);

  logic [STEP_W-1:0] step_q, step_d;
  logic              halted_q, halted_d;

  // Microcode decode of the current step. dec_last marks the final step of
  // the instruction; dec_hlt marks HLT at T2. A step past the end of the
  // current opcode (only reachable if the IR changed mid-instruction) emits
  // nothing and ends the instruction so the sequencer re-enters fetch.
  logic [15:0] dec_ctrl;
  logic        dec_last;
  logic        dec_hlt;

  always_comb begin
    dec_ctrl = 16'h0000;
    dec_last = 1'b0;
    dec_hlt  = 1'b0;
    case (step_q)
      STEP_T0: dec_ctrl = C_CO | C_MI;
      STEP_T1: dec_ctrl = C_RO | C_II | C_CE;
      STEP_T2: begin
        dec_last = 1'b1;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            dec_ctrl = C_IO | C_MI;
            dec_last = 1'b0;
          end
          OP_LDI:  dec_ctrl = C_IO | C_AI;
          OP_JMP:  dec_ctrl = C_IO | C_J;
          OP_JC:   dec_ctrl = flag_c ? (C_IO | C_J) : 16'h0000;
          OP_JZ:   dec_ctrl = flag_z ? (C_IO | C_J) : 16'h0000;
          OP_OUT:  dec_ctrl = C_AO | C_OI;
          OP_HLT: begin
            dec_ctrl = C_HLT;
            dec_hlt  = 1'b1;
          end
          default: dec_ctrl = 16'h0000;
        endcase
      end
      STEP_T3: begin
        dec_last = 1'b1;
        case (opcode)
          OP_LDA:  dec_ctrl = C_RO | C_AI;
          OP_ADD, OP_SUB: begin
            dec_ctrl = C_RO | C_BI;
            dec_last = 1'b0;
          end
          OP_STA:  dec_ctrl = C_AO | C_RI;
          default: dec_ctrl = 16'h0000;
        endcase
      end
      STEP_T4: begin
        dec_last = 1'b1;
        case (opcode)
          OP_ADD:  dec_ctrl = C_EO | C_AI | C_FI;
          OP_SUB:  dec_ctrl = C_EO | C_AI | C_SU | C_FI;
          default: dec_ctrl = 16'h0000;
        endcase
      end
      default: dec_ctrl = 16'h0000;
    endcase
  end

  // Next-state and output gating. Priority: reset, halt, illegal step,
  // step_en. HLT does not wrap step to 0, so it does not raise instr_done;
  // the instruction ends by latching halt instead.
  always_comb begin
    step_d     = step_q;
    halted_d   = halted_q;
    ctrl       = 16'h0000;
    instr_done = 1'b0;
    if (!reset) begin
      if (halted_q) begin
        ctrl = C_HLT;
      end else if (step_q > STEP_T4) begin
        step_d = STEP_T0;
      end else if (step_en) begin
        ctrl = dec_ctrl;
        if (dec_hlt) begin
          halted_d = 1'b1;
        end else if (dec_last) begin
          step_d     = STEP_T0;
          instr_done = 1'b1;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q   <= STEP_T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  assign step   = step_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq -- self-checking bench for ctrl_seq.
// Each cycle: inputs are driven 1 ns after posedge, the expected
// {ctrl, step, instr_done, halted} is pushed to exp_q, and at the negedge the
// DUT outputs are compared against the popped entry.
module tb_ctrl_seq;
  localparam int OP_W   = 4;
  localparam int STEP_W = 3;
  localparam int W      = 16 + STEP_W + 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              step_en;
  logic [OP_W-1:0]   opcode;
  logic              flag_c;
  logic              flag_z;
  logic [15:0]       ctrl;
  logic [STEP_W-1:0] step;
  logic              halted;
  logic              instr_done;

  typedef struct {
    logic              rst;
    logic              en;
    logic [OP_W-1:0]   op;
    logic              fc;
    logic              fz;
    logic [15:0]       ctrl;
    logic [STEP_W-1:0] step;
    logic              done;
    logic              halt;
  } vec_t;

  vec_t          vec_q[$];
  logic [W-1:0]  exp_q[$];
  int            checks = 0;
  int            errors = 0;

  ctrl_seq #(.OP_W(OP_W), .STEP_W(STEP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .step_en    (step_en),
    .opcode     (opcode),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .ctrl       (ctrl),
    .step       (step),
    .halted     (halted),
    .instr_done (instr_done)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Driver: apply one cycle of stimulus and check at the negedge.
  task automatic drive_cycle(input vec_t v, input string name);
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    reset   = v.rst;
    step_en = v.en;
    opcode  = v.op;
    flag_c  = v.fc;
    flag_z  = v.fz;
    exp_q.push_back({v.ctrl, v.step, v.done, v.halt});
    @(negedge clk);
    exp_v = exp_q.pop_front();
    act_v = {ctrl, step, instr_done, halted};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got ctrl=%h step=%0d done=%b halted=%b, want ctrl=%h step=%0d done=%b halted=%b",
               name, act_v[W-1 -: 16], act_v[STEP_W+1:2], act_v[1], act_v[0],
               exp_v[W-1 -: 16], exp_v[STEP_W+1:2], exp_v[1], exp_v[0]);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rst, input logic en, input int op,
                              input logic fc, input logic fz, input logic [15:0] c,
                              input int s, input logic d, input logic h);
    vec_t v;
    v.rst  = rst;
    v.en   = en;
    v.op   = OP_W'(op);
    v.fc   = fc;
    v.fz   = fz;
    v.ctrl = c;
    v.step = STEP_W'(s);
    v.done = d;
    v.halt = h;
    return v;
  endfunction

  // Full instruction with step_en=1, fetch included.
  task automatic add_fetch(input int op, input logic fc, input logic fz);
    vec_q.push_back(mk(0, 1, op, fc, fz, 16'h4004, 0, 0, 0));
    vec_q.push_back(mk(0, 1, op, fc, fz, 16'h1408, 1, 0, 0));
  endtask

  task automatic add_short(input int op, input logic fc, input logic fz, input logic [15:0] t2);
    add_fetch(op, fc, fz);
    vec_q.push_back(mk(0, 1, op, fc, fz, t2, 2, 1, 0));
  endtask

  initial begin
    reset = 1'b1; step_en = 1'b0; opcode = '0; flag_c = 1'b0; flag_z = 1'b0;
    @(posedge clk);
    #1;

    // Table: reset, then every opcode class.
    for (int i = 0; i < 3; i++) vec_q.push_back(mk(1, 1, 0, 0, 0, 16'h0000, 0, 0, 0));
    // LDA
    add_fetch(1, 0, 0);
    vec_q.push_back(mk(0, 1, 1, 0, 0, 16'h4800, 2, 0, 0));
    vec_q.push_back(mk(0, 1, 1, 0, 0, 16'h1200, 3, 1, 0));
    // SUB
    add_fetch(3, 0, 0);
    vec_q.push_back(mk(0, 1, 3, 0, 0, 16'h4800, 2, 0, 0));
    vec_q.push_back(mk(0, 1, 3, 0, 0, 16'h1020, 3, 0, 0));
    vec_q.push_back(mk(0, 1, 3, 0, 0, 16'h02C1, 4, 1, 0));
    // ADD
    add_fetch(2, 0, 0);
    vec_q.push_back(mk(0, 1, 2, 0, 0, 16'h4800, 2, 0, 0));
    vec_q.push_back(mk(0, 1, 2, 0, 0, 16'h1020, 3, 0, 0));
    vec_q.push_back(mk(0, 1, 2, 0, 0, 16'h0281, 4, 1, 0));
    // STA
    add_fetch(4, 0, 0);
    vec_q.push_back(mk(0, 1, 4, 0, 0, 16'h4800, 2, 0, 0));
    vec_q.push_back(mk(0, 1, 4, 0, 0, 16'h2100, 3, 1, 0));
    // 3-cycle instructions
    add_short(0,  0, 0, 16'h0000);  // NOP
    add_short(7,  0, 1, 16'h0000);  // JC, carry clear
    add_short(7,  1, 0, 16'h0802);  // JC, carry set
    add_short(8,  0, 1, 16'h0802);  // JZ, zero set
    add_short(8,  1, 0, 16'h0000);  // JZ, zero clear
    add_short(5,  0, 0, 16'h0A00);  // LDI
    add_short(6,  0, 0, 16'h0802);  // JMP
    add_short(14, 0, 0, 16'h0110);  // OUT
    add_short(11, 1, 1, 16'h0000);  // undefined -> NOP
    // JC: carry only matters at T2
    vec_q.push_back(mk(0, 1, 7, 1, 0, 16'h4004, 0, 0, 0));
    vec_q.push_back(mk(0, 1, 7, 1, 0, 16'h1408, 1, 0, 0));
    vec_q.push_back(mk(0, 1, 7, 0, 0, 16'h0000, 2, 1, 0));
    // step_en=0 at T0 freezes and suppresses
    vec_q.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 0, 0, 0));
    vec_q.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 0, 0, 0));

    foreach (vec_q[i]) drive_cycle(vec_q[i], $sformatf("vec%0d", i));

    // ADD with step_en dropped at T3 for 4 cycles.
    drive_cycle(mk(0, 1, 2, 0, 0, 16'h4004, 0, 0, 0), "stall_t0");
    drive_cycle(mk(0, 1, 2, 0, 0, 16'h1408, 1, 0, 0), "stall_t1");
    drive_cycle(mk(0, 1, 2, 0, 0, 16'h4800, 2, 0, 0), "stall_t2");
    for (int i = 0; i < 4; i++)
      drive_cycle(mk(0, 0, 2, 0, 0, 16'h0000, 3, 0, 0), $sformatf("stall_hold%0d", i));
    drive_cycle(mk(0, 1, 2, 0, 0, 16'h1020, 3, 0, 0), "stall_t3");
    drive_cycle(mk(0, 1, 2, 0, 0, 16'h0281, 4, 1, 0), "stall_t4");
    drive_cycle(mk(0, 1, 2, 0, 0, 16'h4004, 0, 0, 0), "stall_wrap");
    drive_cycle(mk(0, 1, 3, 0, 0, 16'h1408, 1, 0, 0), "rst_t1");

    // SUB aborted by reset at T3.
    drive_cycle(mk(0, 1, 3, 0, 0, 16'h4800, 2, 0, 0), "rst_t2");
    drive_cycle(mk(1, 1, 3, 0, 0, 16'h0000, 3, 0, 0), "rst_during");
    drive_cycle(mk(0, 1, 3, 0, 0, 16'h4004, 0, 0, 0), "rst_after");
    drive_cycle(mk(0, 1, 3, 0, 0, 16'h1408, 1, 0, 0), "rst_after_t1");
    drive_cycle(mk(0, 1, 3, 0, 0, 16'h4800, 2, 0, 0), "rst_after_t2");
    drive_cycle(mk(0, 1, 3, 0, 0, 16'h1020, 3, 0, 0), "rst_after_t3");
    drive_cycle(mk(0, 1, 3, 0, 0, 16'h02C1, 4, 1, 0), "rst_after_t4");

    // HLT: latch, hold with random opcode/step_en, then reset.
    drive_cycle(mk(0, 1, 15, 0, 0, 16'h4004, 0, 0, 0), "hlt_t0");
    drive_cycle(mk(0, 1, 15, 0, 0, 16'h1408, 1, 0, 0), "hlt_t1");
    drive_cycle(mk(0, 1, 15, 0, 0, 16'h8000, 2, 0, 0), "hlt_t2");
    for (int i = 0; i < 10; i++)
      drive_cycle(mk(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     16'h8000, 2, 0, 1), $sformatf("hlt_hold%0d", i));
    drive_cycle(mk(1, 1, 0, 0, 0, 16'h0000, 2, 0, 1), "hlt_reset");
    drive_cycle(mk(0, 1, 0, 0, 0, 16'h4004, 0, 0, 0), "hlt_cleared");
    drive_cycle(mk(0, 1, 0, 0, 0, 16'h1408, 1, 0, 0), "hlt_cleared_t1");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
